// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package pe_pkg;

  localparam int unsigned DT_W = 3;
  localparam logic [DT_W-1:0] DT_FP754 = 3'd0;
  localparam logic [DT_W-1:0] DT_BF8   = 3'd1;
  localparam logic [DT_W-1:0] DT_BF16  = 3'd2;
  localparam logic [DT_W-1:0] DT_INT8  = 3'd3;
  localparam logic [DT_W-1:0] DT_INT16 = 3'd4;
  localparam logic [DT_W-1:0] DT_INT32 = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } pe_state_e;

  localparam int unsigned MAX_W     = 128;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_W);

  // Sign- or zero-extend the low prod_w bits of prod to MAX_W; callers truncate to ACC_W.
  function automatic logic [MAX_W-1:0] ext_acc(input logic [MAX_W-1:0] prod,
                                              input int unsigned     prod_w,
                                              input logic            is_signed);
    logic [MAX_W-1:0] mask;
    logic             fill;
    mask = (MAX_W'(1) << prod_w) - MAX_W'(1);
    fill = is_signed & prod[MAX_IDX_W'(prod_w - 1)];
    return (prod & mask) | ({MAX_W{fill}} & ~mask);
  endfunction

endpackage

// File: rtl/pe_mac_mul_pipe.sv
// Pipelined DATA_W x DATA_W multiplier carrying valid/first/last tags per stage.
module mul_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned SIGNED  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  valid_o,
  output logic                  first_o,
  output logic                  last_o,
  output logic [2*DATA_W-1:0]   prod_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0]  a_ext, b_ext, prod_c;
  logic [MUL_LAT-1:0] vld_q, first_q, last_q;
  logic [PROD_W-1:0]  prod_q [MUL_LAT];

  // Extending both operands to the product width makes the truncated product exact.
  always_comb begin
    a_ext  = (SIGNED != 0) ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
    b_ext  = (SIGNED != 0) ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
    prod_c = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      for (int k = 1; k < MUL_LAT; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    prod_q[0]  <= prod_c;
    first_q[0] <= first_i;
    last_q[0]  <= last_i;
    for (int k = 1; k < MUL_LAT; k++) begin
      prod_q[k]  <= prod_q[k-1];
      first_q[k] <= first_q[k-1];
      last_q[k]  <= last_q[k-1];
    end
  end

  assign valid_o = vld_q[MUL_LAT-1];
  assign first_o = first_q[MUL_LAT-1];
  assign last_o  = last_q[MUL_LAT-1];
  assign prod_o  = prod_q[MUL_LAT-1];

endmodule

// File: rtl/pe_mac.sv
// Systolic MAC processing element: forwards operands east/south and accumulates a framed dot product.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_W   = 2 * DATA_W + 8,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned SIGNED  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] row_in,
  input  logic [DATA_W-1:0] col_in,
  input  logic              in_first,
  input  logic              in_last,
  output logic [DATA_W-1:0] row_out,
  output logic [DATA_W-1:0] col_out,
  output logic              fwd_valid,
  output logic              fwd_first,
  output logic              fwd_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  pe_state_e          state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               accept;
  logic               pipe_valid, pipe_first, pipe_last;
  logic [PROD_W-1:0]  pipe_prod;
  logic [ACC_W-1:0]   acc_q, acc_d, prod_ext;
  logic [ACC_W:0]     sum;
  logic               add_ovf, ovf_q, ovf_d;
  logic [DATA_W-1:0]  row_q, col_q;
  logic               fwd_valid_q, fwd_first_q, fwd_last_q;

  assign accept = in_valid && in_ready_q;

  mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT),
    .SIGNED  (SIGNED)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept),
    .first_i (in_first),
    .last_i  (in_last),
    .a_i     (row_in),
    .b_i     (col_in),
    .valid_o (pipe_valid),
    .first_o (pipe_first),
    .last_o  (pipe_last),
    .prod_o  (pipe_prod)
  );

  // State and FSM-owned output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = in_last ? DRAIN : ACCUM;
      DRAIN:       if (pipe_valid && pipe_last) state_d = HOLD;
      HOLD:        if (res_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    if (state_d == IDLE || state_d == ACCUM) in_ready_d = 1'b1;
    if (state_d == HOLD) res_valid_d = 1'b1;
  end

  // Accumulator: first-tagged product replaces, others add with wrap; overflow is sticky.
  always_comb begin
    prod_ext = ACC_W'(ext_acc(MAX_W'(pipe_prod), PROD_W, SIGNED != 0));
    sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    if (SIGNED != 0)
      add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum[ACC_W];
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (state_q == HOLD && res_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (pipe_valid) begin
      if (pipe_first) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Forwarding path has no backpressure: loads on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      fwd_valid_q <= 1'b0;
      fwd_first_q <= 1'b0;
      fwd_last_q  <= 1'b0;
    end else begin
      fwd_valid_q <= accept;
      if (accept) begin
        row_q       <= row_in;
        col_q       <= col_in;
        fwd_first_q <= in_first;
        fwd_last_q  <= in_last;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;
  assign row_out   = row_q;
  assign col_out   = col_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_first = fwd_first_q;
  assign fwd_last  = fwd_last_q;

endmodule

// File: tb/tb_pe_mac.sv
// Directed bench for pe_mac: three configurations (8b signed, 16b unsigned, 32b signed).
module tb_pe_mac;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   fwd_cnt;

  // DUT A: DATA_W=8, signed, ACC_W=24
  logic        a_in_valid, a_in_ready, a_first, a_last, a_res_ready;
  logic [7:0]  a_row, a_col, a_row_out, a_col_out;
  logic        a_fwd_valid, a_fwd_first, a_fwd_last, a_res_valid, a_res_ovf;
  logic [23:0] a_res_data;
  // DUT B: DATA_W=16, unsigned, ACC_W=32
  logic        b_in_valid, b_in_ready, b_first, b_last, b_res_ready;
  logic [15:0] b_row, b_col, b_row_out, b_col_out;
  logic        b_fwd_valid, b_fwd_first, b_fwd_last, b_res_valid, b_res_ovf;
  logic [31:0] b_res_data;
  // DUT C: DATA_W=32, signed, ACC_W=72
  logic        c_in_valid, c_in_ready, c_first, c_last, c_res_ready;
  logic [31:0] c_row, c_col, c_row_out, c_col_out;
  logic        c_fwd_valid, c_fwd_first, c_fwd_last, c_res_valid, c_res_ovf;
  logic [71:0] c_res_data;

  pe_mac #(.DATA_W(8), .ACC_W(24), .MUL_LAT(3), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .row_in(a_row), .col_in(a_col), .in_first(a_first), .in_last(a_last),
    .row_out(a_row_out), .col_out(a_col_out), .fwd_valid(a_fwd_valid),
    .fwd_first(a_fwd_first), .fwd_last(a_fwd_last), .res_valid(a_res_valid),
    .res_ready(a_res_ready), .res_data(a_res_data), .res_ovf(a_res_ovf));

  pe_mac #(.DATA_W(16), .ACC_W(32), .MUL_LAT(3), .SIGNED(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .row_in(b_row), .col_in(b_col), .in_first(b_first), .in_last(b_last),
    .row_out(b_row_out), .col_out(b_col_out), .fwd_valid(b_fwd_valid),
    .fwd_first(b_fwd_first), .fwd_last(b_fwd_last), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_data(b_res_data), .res_ovf(b_res_ovf));

  pe_mac #(.DATA_W(32), .ACC_W(72), .MUL_LAT(3), .SIGNED(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .row_in(c_row), .col_in(c_col), .in_first(c_first), .in_last(c_last),
    .row_out(c_row_out), .col_out(c_col_out), .fwd_valid(c_fwd_valid),
    .fwd_first(c_fwd_first), .fwd_last(c_fwd_last), .res_valid(c_res_valid),
    .res_ready(c_res_ready), .res_data(c_res_data), .res_ovf(c_res_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (a_fwd_valid) fwd_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_pair(input logic [7:0] r, input logic [7:0] c, input logic f, input logic l);
    a_in_valid = 1'b1; a_row = r; a_col = c; a_first = f; a_last = l;
    tick();
    a_in_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
  endtask

  task automatic b_pair(input logic [15:0] r, input logic [15:0] c, input logic f, input logic l);
    b_in_valid = 1'b1; b_row = r; b_col = c; b_first = f; b_last = l;
    tick();
    b_in_valid = 1'b0; b_first = 1'b0; b_last = 1'b0;
  endtask

  task automatic c_pair(input logic [31:0] r, input logic [31:0] c, input logic f, input logic l);
    c_in_valid = 1'b1; c_row = r; c_col = c; c_first = f; c_last = l;
    tick();
    c_in_valid = 1'b0; c_first = 1'b0; c_last = 1'b0;
  endtask

  function automatic logic res_v(input int sel);
    return (sel == 0) ? a_res_valid : (sel == 1) ? b_res_valid : c_res_valid;
  endfunction

  // Cycles from the last accept until res_valid; capped at 20.
  task automatic wait_res(input int sel, output int cyc);
    cyc = 0;
    while (!res_v(sel) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake(input int sel);
    if (sel == 0) a_res_ready = 1'b1;
    else if (sel == 1) b_res_ready = 1'b1;
    else c_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0; b_res_ready = 1'b0; c_res_ready = 1'b0;
  endtask

  task automatic check_a_reset(input string pfx);
    check({pfx, "_in_ready"},  a_in_ready,  1'b1);
    check({pfx, "_row_out"},   a_row_out,   8'h00);
    check({pfx, "_col_out"},   a_col_out,   8'h00);
    check({pfx, "_fwd_valid"}, a_fwd_valid, 1'b0);
    check({pfx, "_fwd_first"}, a_fwd_first, 1'b0);
    check({pfx, "_fwd_last"},  a_fwd_last,  1'b0);
    check({pfx, "_res_valid"}, a_res_valid, 1'b0);
    check({pfx, "_res_data"},  a_res_data,  24'h0);
    check({pfx, "_res_ovf"},   a_res_ovf,   1'b0);
  endtask

  initial begin
    int   cyc;
    logic seen;
    n_checks = 0; n_errors = 0; fwd_cnt = 0;
    rst = 1'b1;
    a_in_valid = 0; a_first = 0; a_last = 0; a_res_ready = 0; a_row = 0; a_col = 0;
    b_in_valid = 0; b_first = 0; b_last = 0; b_res_ready = 0; b_row = 0; b_col = 0;
    c_in_valid = 0; c_first = 0; c_last = 0; c_res_ready = 0; c_row = 0; c_col = 0;
    tick();
    tick();
    check_a_reset("rst");
    rst = 1'b0;
    fwd_cnt = 0;

    // 3*4 + (-2)*5 + 7*(-1) = -5
    a_pair(8'd3, 8'd4, 1'b1, 1'b0);
    check("t1_fwd_valid", a_fwd_valid, 1'b1);
    check("t1_row_out",   a_row_out,   8'd3);
    check("t1_col_out",   a_col_out,   8'd4);
    check("t1_fwd_first", a_fwd_first, 1'b1);
    a_pair(8'hFE, 8'd5, 1'b0, 1'b0);
    a_pair(8'd7, 8'hFF, 1'b0, 1'b1);
    check("t1_fwd_last",  a_fwd_last,  1'b1);
    check("t1_in_ready_drain", a_in_ready, 1'b0);
    wait_res(0, cyc);
    check("t1_latency",  cyc,        3);
    check("t1_res_data", a_res_data, 24'hFFFFFB);
    check("t1_res_ovf",  a_res_ovf,  1'b0);
    check("t1_fwd_cnt",  fwd_cnt,    3);
    handshake(0);
    check("t1_res_valid_after", a_res_valid, 1'b0);
    check("t1_in_ready_after",  a_in_ready,  1'b1);

    // Single-term 6*7 held under backpressure
    a_pair(8'd6, 8'd7, 1'b1, 1'b1);
    wait_res(0, cyc);
    check("t3_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_data",     a_res_data,  24'd42);
      check("t3_hold_valid",    a_res_valid, 1'b1);
      check("t3_hold_in_ready", a_in_ready,  1'b0);
      tick();
    end
    check("t3_pre_hs_data", a_res_data, 24'd42);
    handshake(0);
    check("t3_in_ready_after",  a_in_ready,  1'b1);
    check("t3_res_valid_after", a_res_valid, 1'b0);

    // Reset one cycle after a last accept drops the result
    a_pair(8'd9, 8'd9, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a_reset("t4_rst");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | a_res_valid;
    end
    check("t4_no_result", seen, 1'b0);
    a_pair(8'd2, 8'd2, 1'b1, 1'b1);
    wait_res(0, cyc);
    check("t4_latency",  cyc,        3);
    check("t4_res_data", a_res_data, 24'd4);
    handshake(0);

    // First re-asserted mid-sum restarts: 2*3 = 6
    a_pair(8'd5, 8'd5, 1'b1, 1'b0);
    a_pair(8'd1, 8'd1, 1'b0, 1'b0);
    a_pair(8'd2, 8'd3, 1'b1, 1'b1);
    wait_res(0, cyc);
    check("t5_res_data", a_res_data, 24'd6);
    check("t5_res_ovf",  a_res_ovf,  1'b0);
    handshake(0);

    // No first tag from IDLE accumulates onto 0: (-3)*4 + 2*2 = -8
    a_pair(8'hFD, 8'd4, 1'b0, 1'b0);
    a_pair(8'd2, 8'd2, 1'b0, 1'b1);
    wait_res(0, cyc);
    check("t6_res_data", a_res_data, 24'hFFFFF8);
    handshake(0);

    // Unsigned carry out: 2*0xFFFE0001 wraps to 0xFFFC0002
    b_pair(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    b_pair(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_res(1, cyc);
    check("t2_latency",  cyc,        3);
    check("t2_res_data", b_res_data, 32'hFFFC0002);
    check("t2_res_ovf",  b_res_ovf,  1'b1);
    handshake(1);
    check("t2_res_valid_after", b_res_valid, 1'b0);
    b_pair(16'd2, 16'd3, 1'b1, 1'b1);
    wait_res(1, cyc);
    check("t2b_res_data", b_res_data, 32'd6);
    check("t2b_res_ovf",  b_res_ovf,  1'b0);
    handshake(1);

    // Most-negative squared: 2^62 in a 72-bit accumulator
    c_pair(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_res(2, cyc);
    check("t7_latency",  cyc,        3);
    check("t7_res_data", c_res_data, 72'h00_4000_0000_0000_0000);
    check("t7_res_ovf",  c_res_ovf,  1'b0);
    handshake(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised systolic multiply-accumulate processing element for the matrix multiplier array. It accepts one operand pair per cycle through a valid/ready handshake and forwards the operands to its east and south neighbours one cycle later. Operands feed an internal pipelined multiplier, and products are accumulated into a dot product framed by first/last tags. The finished result leaves through a valid/ready result port with a sticky overflow flag.

## Interface
- DATA_W, 32, operand width; legal values 8, 16, 32
- ACC_W, 2*DATA_W+8, accumulator and result width; must be ≥ 2*DATA_W
- MUL_LAT, 3, multiplier pipeline depth in cycles; must be ≥ 1
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  PE can accept a pair this cycle
- row_in  in  DATA_W  A operand (from west)
- col_in  in  DATA_W  B operand (from north)
- in_first  in  1  pair is the first term of a dot product
- in_last  in  1  pair is the last term of a dot product
- row_out  out  DATA_W  registered row_in to east neighbour
- col_out  out  DATA_W  registered col_in to south neighbour
- fwd_valid  out  1  row_out/col_out valid, with first/last tags
- fwd_first, fwd_last  out  1 each  forwarded tags
- res_valid  out  1  dot-product result pending
- res_ready  in  1  consumer takes result
- res_data  out  ACC_W  accumulated result
- res_ovf  out  1  accumulator overflowed during this dot product

## Operation
- A pair is accepted when in_valid && in_ready. There is no other accept path.
- States:
  - IDLE: no dot product open.
  - ACCUM: dot product open.
  - DRAIN: last pair accepted, still in the pipeline.
  - HOLD: result valid, waiting for res_ready.
- Transitions:
  - IDLE→ACCUM on an accept without in_last.
  - IDLE/ACCUM→DRAIN on an accept with in_last.
  - DRAIN→HOLD when the last product exits the multiplier.
  - HOLD→IDLE on res_ready.
- in_ready = 1 only in IDLE or ACCUM.
  - Throughput is 1 pair/cycle within a dot product.
  - There are MUL_LAT+1 idle cycles between dot products, plus HOLD time.
- Accumulation:
  - A product tagged first replaces the accumulator.
  - Other products add to it.
  - The accumulator is 0 after reset and after each HOLD→IDLE.
- Width rules:
  - Products are full 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED.
  - Addition wraps modulo 2^ACC_W.
- Overflow:
  - res_ovf sets on signed overflow (SIGNED=1) or carry out (SIGNED=0) of any add within the dot product.
  - It clears with a first-tagged product.
- A pair with both in_first and in_last is a single-term dot product: res_data = product.
- A pair without in_first arriving in IDLE accumulates onto 0.
- in_first arriving in ACCUM abandons the open sum and restarts. No error is flagged.
- Forwarding:
  - row_out/col_out/tags load on every accept.
  - fwd_valid pulses for one cycle per accept.
  - The forwarding path has no backpressure; neighbours must always accept.
- res_data and res_ovf stay stable while res_valid && !res_ready.

## Timing
- Reset values: in_ready 1, row_out 0, col_out 0, fwd_valid 0, fwd_first 0, fwd_last 0, res_valid 0, res_data 0, res_ovf 0. State IDLE, accumulator 0, pipeline valids 0.
- rst mid-operation:
  - In-flight products are discarded.
  - Any pending result is dropped.
  - Outputs return to reset values on the next edge.
- Pair accepted at edge E:
  - row_out/col_out/fwd_valid are visible after E.
  - The product enters the accumulator at edge E+MUL_LAT.
- Last pair accepted at edge E: res_valid rises after edge E+MUL_LAT. The minimum result latency is MUL_LAT cycles.
- res_valid && res_ready at edge F: res_valid low after F and in_ready high after F. The earliest next accept is edge F+1.
- res_ready while res_valid=0 is ignored.

## Structure
- Shared package pe_pkg holds:
  - the data-type encoding constants (fpu 754, bfloat 8, bfloat 16, int 8, int 16, int 32);
  - the state enum (IDLE, ACCUM, DRAIN, HOLD);
  - the helper function for ACC_W sign/zero extension.
- One sub-module, mul_pipe:
  - DATA_W×DATA_W multiplier with MUL_LAT stages.
  - valid, first and last tags carried alongside the data through each stage.
  - Parameterised SIGNED.
  - Synchronous active-high rst clears the stage valids.

## Test plan
- DATA_W=8, SIGNED=1, MUL_LAT=3:
  - Stimulus: back-to-back pairs (3,4),(−2,5),(7,−1); first on pair 1, last on pair 3.
  - Response: res_data=−5, res_ovf=0; res_valid rises 3 cycles after the last accept; fwd_valid pulses 3 times.
- DATA_W=16, SIGNED=0, ACC_W=32:
  - Stimulus: two pairs (0xFFFF,0xFFFF), first then last.
  - Response: res_data=0xFFFC0002, res_ovf=1.
- Single-term dot product with first+last on (6,7):
  - Hold res_ready=0 for 5 cycles, then 1.
  - Response: res_data=42 stable throughout; in_ready=0 until the cycle after the handshake.
- rst asserted one cycle after a last accept:
  - Response: res_valid never rises; all outputs return to reset values.
  - A following dot product (2,2) first+last gives 4.
- in_first re-asserted mid-sum:
  - Stimulus: (5,5) first, (1,1), then (2,3) first+last.
  - Response: res_data=6.
- SIGNED=1, DATA_W=32:
  - Stimulus: (0x80000000,0x80000000) single term.
  - Response: res_data=2^62, res_ovf=0.
